// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller and the display logic that reads its status.
// State encoding here is what the board sees on the two status LEDs.
package pong_pkg;

    localparam int SCORE_W = 6;
    localparam int TIME_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

endpackage

// File: rtl/pong_sec_tick.sv
// One-second tick generator: counts 0..CLK_HZ-1 and flags the last cycle of each second.
// A restart zeroes the count so seconds are measured from the moment a game phase begins.
module pong_sec_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/pong_round_controller.sv
// Round sequencer for the IR pong game: get-ready countdown, timed play period, win/time-out
// detection, session high score, score-clear pulse and a beeper that follows score increments.
module pong_round_controller
    import pong_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int READY_SECONDS = 3,
    parameter int ROUND_SECONDS = 60,
    parameter int TARGET_SCORE  = 50,
    parameter int BEEP_CYCLES   = 10_000_000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               i_start_pulse,
    input  logic [SCORE_W-1:0] i_score_in,
    output logic               o_score_clear,
    output logic [1:0]         o_state_out,
    output logic [TIME_W-1:0]  o_time_left,
    output logic [SCORE_W-1:0] o_high_score,
    output logic               o_beep,
    output logic               o_win
);

    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [TIME_W-1:0]   r_timeLeft;
    logic [SCORE_W-1:0]  r_highScore;
    logic [SCORE_W-1:0]  r_prevScore;
    logic [BEEP_W-1:0]   r_beepCnt;
    logic                r_beep;
    logic                r_win;
    logic                r_scoreClear;
    logic                w_tick;
    logic                w_restart;
    logic                w_lastSecond;
    logic                w_targetHit;
    logic                w_scoreUp;

    pong_sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_lastSecond = w_tick && (r_timeLeft == TIME_W'(1));
    assign w_targetHit  = (i_score_in >= SCORE_W'(TARGET_SCORE));
    assign w_scoreUp    = (r_state == ST_PLAY) && (i_score_in > r_prevScore);
    assign w_restart    = (w_nextState != r_state);

    // Reaching the target wins even when the clock runs out on the same cycle.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start_pulse) w_nextState = ST_READY;
            ST_READY: if (w_lastSecond) w_nextState = ST_PLAY;
            ST_PLAY:  if (w_targetHit || w_lastSecond) w_nextState = ST_OVER;
            ST_OVER:  if (i_start_pulse) w_nextState = ST_READY;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_timeLeft   <= '0;
            r_win        <= 1'b0;
            r_scoreClear <= 1'b0;
            r_highScore  <= '0;
        end else begin
            r_state      <= w_nextState;
            r_scoreClear <= w_restart && (w_nextState == ST_READY);
            if (w_restart) begin
                case (w_nextState)
                    ST_READY: r_timeLeft <= TIME_W'(READY_SECONDS);
                    ST_PLAY:  r_timeLeft <= TIME_W'(ROUND_SECONDS);
                    default:  r_timeLeft <= '0;
                endcase
                r_win <= (w_nextState == ST_OVER) && w_targetHit;
                if ((w_nextState == ST_OVER) && (i_score_in > r_highScore)) begin
                    r_highScore <= i_score_in;
                end
            end else if (w_tick && ((r_state == ST_READY) || (r_state == ST_PLAY))) begin
                r_timeLeft <= r_timeLeft - TIME_W'(1);
            end
        end
    end

    // prev_score tracks every cycle so points scored during the countdown never beep at play start.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_prevScore <= '0;
            r_beepCnt   <= '0;
            r_beep      <= 1'b0;
        end else begin
            r_prevScore <= i_score_in;
            if (w_scoreUp) begin
                r_beepCnt <= BEEP_W'(BEEP_CYCLES - 1);
                r_beep    <= 1'b1;
            end else if (r_beepCnt != '0) begin
                r_beepCnt <= r_beepCnt - BEEP_W'(1);
            end else begin
                r_beep <= 1'b0;
            end
        end
    end

    assign o_score_clear = r_scoreClear;
    assign o_state_out   = r_state;
    assign o_time_left   = r_timeLeft;
    assign o_high_score  = r_highScore;
    assign o_beep        = r_beep;
    assign o_win         = r_win;

endmodule

// File: tb/tb_pong_round_controller.sv
// Self-checking bench for pong_round_controller: directed round scenarios followed by random
// start/score traffic, all compared every cycle against a phase-age based reference model.
module tb_pong_round_controller;

    localparam int CLK_HZ  = 10;
    localparam int READY_S = 3;
    localparam int ROUND_S = 5;
    localparam int TARGET  = 4;
    localparam int BEEP    = 3;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b0;
    logic       i_start_pulse = 1'b0;
    logic [5:0] i_score_in = '0;
    logic       o_score_clear;
    logic [1:0] o_state_out;
    logic [6:0] o_time_left;
    logic [5:0] o_high_score;
    logic       o_beep;
    logic       o_win;

    always #5 clk_100MHz = ~clk_100MHz;

    pong_round_controller #(
        .CLK_HZ       (CLK_HZ),
        .READY_SECONDS(READY_S),
        .ROUND_SECONDS(ROUND_S),
        .TARGET_SCORE (TARGET),
        .BEEP_CYCLES  (BEEP)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .i_start_pulse(i_start_pulse),
        .i_score_in   (i_score_in),
        .o_score_clear(o_score_clear),
        .o_state_out  (o_state_out),
        .o_time_left  (o_time_left),
        .o_high_score (o_high_score),
        .o_beep       (o_beep),
        .o_win        (o_win)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 ready, 2 play, 3 over; time is derived from phase age.
    int mState, mAge, mHigh, mWin, mClear, mPrev, mCycle, mLastInc;
    bit mBeepValid;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mState = 0; mAge = 0; mHigh = 0; mWin = 0; mClear = 0;
        mPrev = 0; mCycle = 0; mLastInc = 0; mBeepValid = 1'b0;
    endtask

    function automatic int modelTimeLeft();
        if (mState == 1) return READY_S - mAge / CLK_HZ;
        if (mState == 2) return ROUND_S - mAge / CLK_HZ;
        return 0;
    endfunction

    function automatic int modelBeep();
        return (mBeepValid && (mCycle - mLastInc) < BEEP) ? 1 : 0;
    endfunction

    task automatic modelStep(input bit st, input int sc);
        int nxt;
        bit hit;
        mCycle++;
        hit = (sc >= TARGET);
        nxt = mState;
        case (mState)
            0: if (st) nxt = 1;
            1: if (mAge + 1 == READY_S * CLK_HZ) nxt = 2;
            2: if (hit || (mAge + 1 == ROUND_S * CLK_HZ)) nxt = 3;
            default: if (st) nxt = 1;
        endcase
        if (mState == 2 && sc > mPrev) begin
            mBeepValid = 1'b1;
            mLastInc = mCycle;
        end
        mPrev = sc;
        mClear = (nxt == 1 && mState != 1) ? 1 : 0;
        if (nxt != mState) begin
            mAge = 0;
            mWin = (nxt == 3 && hit) ? 1 : 0;
            if (nxt == 3 && sc > mHigh) mHigh = sc;
        end else begin
            mAge++;
        end
        mState = nxt;
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".state"}, int'(o_state_out), mState);
        checkOutput({phase, ".time"}, int'(o_time_left), modelTimeLeft());
        checkOutput({phase, ".high"}, int'(o_high_score), mHigh);
        checkOutput({phase, ".beep"}, int'(o_beep), modelBeep());
        checkOutput({phase, ".win"}, int'(o_win), mWin);
        checkOutput({phase, ".clear"}, int'(o_score_clear), mClear);
    endtask

    task automatic applyStimulus(input bit st, input int sc);
        i_start_pulse = st;
        i_score_in = 6'(sc);
        @(posedge clk_100MHz);
        modelStep(st, sc);
        #1;
        checkAll("cyc");
        i_start_pulse = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        i_start_pulse = 1'b0;
        #2;
        modelReset();
        checkAll("rst");
        @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitState(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(o_state_out) != target && n < budget) begin
            applyStimulus(1'b0, 0);
            n++;
        end
        checkOutput(tag, int'(o_state_out), target);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int sc;
        bit st;
        int r;

        resetDut();

        // Idle after reset: nothing moves, no clear pulse.
        repeat (50) applyStimulus(1'b0, 0);
        checkOutput("idleState", int'(o_state_out), 0);
        checkOutput("idleClear", int'(o_score_clear), 0);

        // Start: one clear pulse, 3 s countdown, play begins exactly 30 cycles later.
        applyStimulus(1'b1, 0);
        checkOutput("clearPulse", int'(o_score_clear), 1);
        checkOutput("readyTime", int'(o_time_left), 3);
        n = 0;
        while (int'(o_state_out) != 2 && n < 100) begin
            applyStimulus(1'b0, 0);
            n++;
            if (n == 10) checkOutput("ready10", int'(o_time_left), 2);
            if (n == 20) checkOutput("ready20", int'(o_time_left), 1);
        end
        checkOutput("readyLen", n, 30);
        checkOutput("playTime", int'(o_time_left), 5);

        // Two score increments, then run out the clock.
        n = 0;
        sc = 0;
        while (int'(o_state_out) == 2 && n < 100) begin
            if (n == 5) sc = 1;
            if (n == 12) sc = 2;
            applyStimulus(1'b0, sc);
            if (n == 5 || n == 12) checkOutput("beepOn", int'(o_beep), 1);
            n++;
        end
        checkOutput("playLen", n, 50);
        checkOutput("timeoutState", int'(o_state_out), 3);
        checkOutput("timeoutWin", int'(o_win), 0);
        checkOutput("timeoutHigh", int'(o_high_score), 2);
        checkOutput("timeoutTime", int'(o_time_left), 0);

        // Restart from OVER, hit the target with 3 s left.
        applyStimulus(1'b1, 0);
        checkOutput("restartClear", int'(o_score_clear), 1);
        checkOutput("restartWin", int'(o_win), 0);
        waitState(2, 100, "toPlay2");
        n = 0;
        while (int'(o_time_left) != 3 && n < 100) begin
            applyStimulus(1'b0, 0);
            n++;
        end
        applyStimulus(1'b0, 4);
        checkOutput("winState", int'(o_state_out), 3);
        checkOutput("winFlag", int'(o_win), 1);
        checkOutput("winHigh", int'(o_high_score), 4);

        // Score drop gives no beep; target reached on the final tick still wins.
        applyStimulus(1'b1, 0);
        waitState(2, 100, "toPlay3");
        for (int k = 0; k < 50; k++) begin
            sc = (k >= 3 && k < 10) ? 3 : ((k == 49) ? 4 : 0);
            applyStimulus(1'b0, sc);
            if (k == 10) checkOutput("dropBeep", int'(o_beep), 0);
            if (k == 48) checkOutput("preFinal", int'(o_state_out), 2);
        end
        checkOutput("tieState", int'(o_state_out), 3);
        checkOutput("tieWin", int'(o_win), 1);
        checkOutput("tieHigh", int'(o_high_score), 4);

        // Start is ignored mid-play; async reset with a beep running clears everything.
        applyStimulus(1'b1, 0);
        waitState(2, 100, "toPlay4");
        applyStimulus(1'b1, 0);
        checkOutput("startIgnored", int'(o_state_out), 2);
        n = 0;
        while (int'(o_time_left) != 2 && n < 100) begin
            applyStimulus(1'b0, 0);
            n++;
        end
        applyStimulus(1'b0, 1);
        reset = 1'b1;
        #2;
        checkOutput("rstState", int'(o_state_out), 0);
        checkOutput("rstHigh", int'(o_high_score), 0);
        checkOutput("rstBeep", int'(o_beep), 0);
        checkOutput("rstTime", int'(o_time_left), 0);
        modelReset();
        @(posedge clk_100MHz);
        #1;
        reset = 1'b0;

        // Random traffic: sparse starts, a wandering score, occasional resets.
        sc = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                resetDut();
            end else begin
                st = ($urandom_range(0, 99) < 3);
                r = $urandom_range(0, 99);
                if (st) sc = 0;
                else if (r < 10) sc = (sc < 63) ? sc + 1 : sc;
                else if (r < 13) sc = $urandom_range(0, 63);
                applyStimulus(st, sc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
